// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU's two memory initiators (instruction
// fetch and data access) and the shared memory responder.
interface mem_responder_if;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ready;
    logic        i_valid;
    logic [15:0] i_data;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ready;
    logic        d_valid;
    logic [15:0] d_rdata;
    logic        busy;

    // CPU side: raises requests, observes handshakes and responses
    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        input  i_ready, i_valid, i_data, d_ready, d_valid, d_rdata, busy
    );

    // Memory side: accepts requests, produces handshakes and responses
    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        output i_ready, i_valid, i_data, d_ready, d_valid, d_rdata, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Multi-cycle main-memory responder for the fetch and data ports of the CPU.
// The data port has strict priority; one transaction is outstanding at a time
// and completes LATENCY cycles after acceptance with a one-cycle valid pulse.
// A new request may be accepted in the cycle the previous response is valid.
module mem_responder #(
    parameter int DEPTH_LOG2 = 15,
    parameter int LATENCY    = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Counter value loaded at acceptance: the access edge is the edge where the
    // counter is zero in a wait state, which puts valid in cycle C+LATENCY.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [3:0]            cnt;
    logic [3:0]            cnt_next;

    logic                  i_valid_q;
    logic                  d_valid_q;
    logic                  busy_q;
    logic [15:0]           i_data_q;
    logic [15:0]           d_rdata_q;

    // Request fields captured at acceptance
    logic [DEPTH_LOG2-1:0] lat_word;
    logic                  lat_wr;
    logic [15:0]           lat_wdata;

    logic [15:0]           mem [DEPTH];

    logic                  can_accept;
    logic                  acc_d;
    logic                  acc_i;
    logic                  acc_any;

    logic                  access;
    logic                  access_d;
    logic                  access_wr;
    logic [DEPTH_LOG2-1:0] access_word;
    logic [15:0]           access_wdata;

    logic                  unused_addr_bits;

    // Bit 0 selects a byte within the word and is deliberately ignored.
    assign unused_addr_bits = ^{bus.i_addr, bus.d_addr};

    // A request is accepted when idle or while the previous response is on the
    // bus; nothing is accepted while reset is held.
    assign can_accept = ~rst & ((state == IDLE) | i_valid_q | d_valid_q);
    assign acc_d      = can_accept & bus.d_req;
    assign acc_i      = can_accept & bus.i_req & ~bus.d_req;
    assign acc_any    = acc_d | acc_i;

    assign bus.d_ready = acc_d;
    assign bus.i_ready = acc_i;
    assign bus.i_valid = i_valid_q;
    assign bus.d_valid = d_valid_q;
    assign bus.i_data  = i_data_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.busy    = busy_q;

    // Next-state, counter and access-edge decode
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        access       = 1'b0;
        access_d     = 1'b0;
        access_wr    = 1'b0;
        access_word  = lat_word;
        access_wdata = lat_wdata;

        if (state != IDLE) begin
            if (cnt != 4'd0) begin
                cnt_next = cnt - 4'd1;
            end else begin
                state_next = IDLE;
                access     = 1'b1;
                access_d   = (state == WAIT_D);
                access_wr  = (state == WAIT_D) & lat_wr;
            end
        end

        if (acc_any) begin
            if (LATENCY == 1) begin
                // Single-cycle latency: the acceptance edge is also the access
                // edge, so the live request fields drive the array directly.
                access       = 1'b1;
                access_d     = acc_d;
                access_wr    = acc_d & bus.d_wr;
                access_word  = acc_d ? bus.d_addr[DEPTH_LOG2:1] : bus.i_addr[DEPTH_LOG2:1];
                access_wdata = bus.d_wdata;
                state_next   = IDLE;
            end else begin
                state_next = acc_d ? WAIT_D : WAIT_I;
                cnt_next   = CNT_LOAD;
            end
        end
    end

    // FSM state and latency counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Response pulses, returned read data and the registered busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            i_data_q  <= 16'h0000;
            d_rdata_q <= 16'h0000;
        end else begin
            i_valid_q <= access & ~access_d;
            d_valid_q <= access & access_d;
            // Busy covers every cycle after acceptance up to and including
            // the valid cycle; the wait states always end on the access edge.
            busy_q    <= acc_any | (state != IDLE);
            if (access & ~access_d) begin
                i_data_q <= mem[access_word];
            end
            if (access & access_d & ~access_wr) begin
                d_rdata_q <= mem[access_word];
            end
        end
    end

    // Capture request fields at acceptance; these are data, so no reset
    always_ff @(posedge clk) begin
        if (acc_any) begin
            lat_word  <= acc_d ? bus.d_addr[DEPTH_LOG2:1] : bus.i_addr[DEPTH_LOG2:1];
            lat_wr    <= acc_d & bus.d_wr;
            lat_wdata <= bus.d_wdata;
        end
    end

    // Array write on the access edge of a data write; contents survive reset
    always_ff @(posedge clk) begin
        if (access & access_wr) begin
            mem[access_word] <= access_wdata;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=4 instance exercises reset, arbitration,
// timing, write/read ordering and reset abort; a LATENCY=1 instance exercises
// full-throughput streaming. Expected responses are queued at acceptance.
module tb_mem_responder;
    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        bit          is_d;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        q4[$];
    exp_t        q1[$];
    logic [15:0] model4 [0:32767];
    logic [15:0] model1 [0:32767];
    logic [15:0] last_d4 = 16'h0000;
    logic [15:0] last_i4 = 16'h0000;
    logic [15:0] last_d1 = 16'h0000;

    mem_responder_if bus4();
    mem_responder_if bus1();

    mem_responder #(.DEPTH_LOG2(15), .LATENCY(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    mem_responder #(.DEPTH_LOG2(15), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1);
    end

    // Record an accepted LATENCY=4 transaction in the scoreboard and model
    task automatic push4(input bit is_d, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wdata);
        exp_t e;
        e.is_d = is_d;
        e.due  = cyc + 4;
        if (is_d && wr) begin
            model4[addr[15:1]] = wdata;
            e.data = last_d4;
        end else begin
            e.data = model4[addr[15:1]];
            if (is_d) last_d4 = e.data;
            else      last_i4 = e.data;
        end
        q4.push_back(e);
    endtask

    // Record an accepted LATENCY=1 data transaction
    task automatic push1(input bit wr, input logic [15:0] addr, input logic [15:0] wdata);
        exp_t e;
        e.is_d = 1'b1;
        e.due  = cyc + 1;
        if (wr) begin
            model1[addr[15:1]] = wdata;
            e.data = last_d1;
        end else begin
            e.data  = model1[addr[15:1]];
            last_d1 = e.data;
        end
        q1.push_back(e);
    endtask

    task automatic pop4(output exp_t e);
        if (q4.size() > 0) begin
            e = q4.pop_front();
        end else begin
            e.is_d = 1'b0;
            e.data = 16'hxxxx;
            e.due  = -1;
        end
    endtask

    task automatic pop1(output exp_t e);
        if (q1.size() > 0) begin
            e = q1.pop_front();
        end else begin
            e.is_d = 1'b0;
            e.data = 16'hxxxx;
            e.due  = -1;
        end
    endtask

    // Raise a request on the LATENCY=4 bus and hold it until accepted
    task automatic req4(input bit is_d, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        if (is_d) begin
            bus4.d_req   = 1'b1;
            bus4.d_wr    = wr;
            bus4.d_addr  = addr;
            bus4.d_wdata = wdata;
        end else begin
            bus4.i_req  = 1'b1;
            bus4.i_addr = addr;
        end
        for (int k = 0; k < 40 && !ok; k++) begin
            #1;
            if (is_d ? bus4.d_ready : bus4.i_ready) begin
                push4(is_d, wr, addr, wdata);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        bus4.i_req = 1'b0;
        bus4.d_req = 1'b0;
    endtask

    // Wait (bounded) for the next response pulse on the LATENCY=4 bus
    task automatic collect4(input int limit, output bit got, output bit is_d,
                            output logic [15:0] data, output int at);
        got  = 1'b0;
        is_d = 1'b0;
        data = 16'h0000;
        at   = -1;
        for (int k = 0; k < limit && !got; k++) begin
            @(negedge clk);
            #1;
            if (bus4.i_valid || bus4.d_valid) begin
                got  = 1'b1;
                is_d = bus4.d_valid;
                data = bus4.d_valid ? bus4.d_rdata : bus4.i_data;
                at   = cyc;
            end
        end
    endtask

    task automatic test_reset();
        bit ok, got, isd;
        logic [15:0] dat;
        int at;
        exp_t e;
        @(negedge clk);
        #1;
        checks++;
        if ({bus4.i_ready, bus4.i_valid, bus4.d_ready, bus4.d_valid, bus4.busy,
             bus4.i_data, bus4.d_rdata} !== 37'd0) begin
            failures++;
            $display("FAIL reset_init: outputs=%h required 0", {bus4.i_ready, bus4.i_valid,
                     bus4.d_ready, bus4.d_valid, bus4.busy, bus4.i_data, bus4.d_rdata});
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus4.i_valid, bus4.d_valid, bus4.busy, bus4.i_data, bus4.d_rdata} !== 35'd0) begin
            failures++;
            $display("FAIL reset_idle: outputs=%h required 0", {bus4.i_valid, bus4.d_valid,
                     bus4.busy, bus4.i_data, bus4.d_rdata});
        end
        @(negedge clk);
        rst = 1'b0;

        req4(1'b1, 1'b1, 16'h0000, 16'h0F0F, ok);
        collect4(12, got, isd, dat, at);
        pop4(e);
        checks++;
        if (!got || isd !== e.is_d || dat !== e.data || at != e.due) begin
            failures++;
            $display("FAIL preload_w0: got valid=%0b d=%0b data=%h cyc=%0d, required d=%0b data=%h cyc=%0d",
                     got, isd, dat, at, e.is_d, e.data, e.due);
        end

        // Read that will be cut short by reset while in WAIT_D
        req4(1'b1, 1'b0, 16'h0000, 16'h0000, ok);
        @(negedge clk);
        rst = 1'b1;
        #1;
        void'(q4.pop_back());
        last_d4 = 16'h0000;
        last_i4 = 16'h0000;
        checks++;
        if ({bus4.i_ready, bus4.i_valid, bus4.d_ready, bus4.d_valid, bus4.busy,
             bus4.i_data, bus4.d_rdata} !== 37'd0) begin
            failures++;
            $display("FAIL reset_wait_d: outputs=%h required 0", {bus4.i_ready, bus4.i_valid,
                     bus4.d_ready, bus4.d_valid, bus4.busy, bus4.i_data, bus4.d_rdata});
        end
        @(negedge clk);
        rst = 1'b0;
        last_d1 = 16'h0000;
        bus4.i_req  = 1'b1;
        bus4.i_addr = 16'h0000;
        #1;
        checks++;
        if (bus4.i_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_accept: i_ready=%b required 1", bus4.i_ready);
        end
        if (bus4.i_ready === 1'b1) push4(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        bus4.i_req = 1'b0;
        collect4(12, got, isd, dat, at);
        pop4(e);
        checks++;
        if (!got || isd !== e.is_d || dat !== e.data || at != e.due) begin
            failures++;
            $display("FAIL reset_after_fetch: got valid=%0b d=%0b data=%h cyc=%0d, required d=%0b data=%h cyc=%0d",
                     got, isd, dat, at, e.is_d, e.data, e.due);
        end
    endtask

    task automatic test_single_read();
        bit ok, got, isd;
        logic [15:0] dat;
        int at;
        exp_t e;
        req4(1'b1, 1'b1, 16'h0010, 16'hABCD, ok);
        collect4(12, got, isd, dat, at);
        pop4(e);
        checks++;
        if (!got || isd !== e.is_d || dat !== e.data || at != e.due) begin
            failures++;
            $display("FAIL preload_abcd: got valid=%0b d=%0b data=%h cyc=%0d, required d=%0b data=%h cyc=%0d",
                     got, isd, dat, at, e.is_d, e.data, e.due);
        end
        @(negedge clk);
        bus4.i_req  = 1'b1;
        bus4.i_addr = 16'h0010;
        #1;
        checks++;
        if (bus4.i_ready !== 1'b1 || bus4.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_c0: i_ready=%b busy=%b required 1/0", bus4.i_ready, bus4.busy);
        end
        push4(1'b0, 1'b0, 16'h0010, 16'h0000);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus4.i_req = 1'b0;
            #1;
            checks++;
            if (bus4.busy !== (k <= 4)) begin
                failures++;
                $display("FAIL single_busy c%0d: busy=%b required %b", k, bus4.busy, (k <= 4));
            end
            checks++;
            if (bus4.i_valid !== (k == 4) || bus4.d_valid !== 1'b0) begin
                failures++;
                $display("FAIL single_valid c%0d: i_valid=%b d_valid=%b required %b/0",
                         k, bus4.i_valid, bus4.d_valid, (k == 4));
            end
            if (k == 4) begin
                pop4(e);
                checks++;
                if (bus4.i_data !== e.data || cyc != e.due) begin
                    failures++;
                    $display("FAIL single_data: i_data=%h cyc=%0d required %h cyc=%0d",
                             bus4.i_data, cyc, e.data, e.due);
                end
            end
        end
    endtask

    task automatic test_arbitration();
        bit ok, got, isd;
        logic [15:0] dat;
        int at;
        exp_t e;
        req4(1'b1, 1'b1, 16'h0002, 16'h2222, ok);
        collect4(12, got, isd, dat, at);
        pop4(e);
        checks++;
        if (!got || isd !== e.is_d || dat !== e.data || at != e.due) begin
            failures++;
            $display("FAIL preload_2222: got valid=%0b d=%0b data=%h cyc=%0d, required d=%0b data=%h cyc=%0d",
                     got, isd, dat, at, e.is_d, e.data, e.due);
        end
        @(negedge clk);
        bus4.i_req  = 1'b1;
        bus4.i_addr = 16'h0010;
        bus4.d_req  = 1'b1;
        bus4.d_wr   = 1'b0;
        bus4.d_addr = 16'h0002;
        #1;
        checks++;
        if (bus4.d_ready !== 1'b1 || bus4.i_ready !== 1'b0) begin
            failures++;
            $display("FAIL arb_priority: d_ready=%b i_ready=%b required 1/0", bus4.d_ready, bus4.i_ready);
        end
        push4(1'b1, 1'b0, 16'h0002, 16'h0000);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) bus4.d_req = 1'b0;
            if (k == 5) bus4.i_req = 1'b0;
            #1;
            checks++;
            if (bus4.i_ready !== (k == 4) || bus4.d_valid !== (k == 4) || bus4.i_valid !== (k == 8)) begin
                failures++;
                $display("FAIL arb_timing c%0d: i_ready=%b d_valid=%b i_valid=%b required %b/%b/%b",
                         k, bus4.i_ready, bus4.d_valid, bus4.i_valid, (k == 4), (k == 4), (k == 8));
            end
            checks++;
            if (bus4.busy !== (k <= 8)) begin
                failures++;
                $display("FAIL arb_busy c%0d: busy=%b required %b", k, bus4.busy, (k <= 8));
            end
            if (bus4.d_valid === 1'b1 || bus4.i_valid === 1'b1) begin
                pop4(e);
                checks++;
                dat = bus4.d_valid ? bus4.d_rdata : bus4.i_data;
                if (bus4.d_valid !== e.is_d || dat !== e.data || cyc != e.due) begin
                    failures++;
                    $display("FAIL arb_data c%0d: d=%b data=%h required d=%b data=%h cyc=%0d",
                             k, bus4.d_valid, dat, e.is_d, e.data, e.due);
                end
            end
            if (k == 4 && bus4.i_ready === 1'b1) push4(1'b0, 1'b0, 16'h0010, 16'h0000);
        end
    endtask

    task automatic test_write_read();
        bit ok, got, isd;
        logic [15:0] dat;
        int at;
        exp_t e;
        req4(1'b1, 1'b1, 16'h0020, 16'h1234, ok);
        collect4(12, got, isd, dat, at);
        pop4(e);
        checks++;
        if (!got || isd !== e.is_d || dat !== e.data || at != e.due) begin
            failures++;
            $display("FAIL write_keeps_rdata: got valid=%0b d=%0b data=%h cyc=%0d, required d=%0b data=%h cyc=%0d",
                     got, isd, dat, at, e.is_d, e.data, e.due);
        end
        req4(1'b1, 1'b0, 16'h0021, 16'h0000, ok);
        collect4(12, got, isd, dat, at);
        pop4(e);
        checks++;
        if (!got || isd !== e.is_d || dat !== e.data || at != e.due) begin
            failures++;
            $display("FAIL read_after_write: got valid=%0b d=%0b data=%h cyc=%0d, required d=%0b data=%h cyc=%0d",
                     got, isd, dat, at, e.is_d, e.data, e.due);
        end
    endtask

    task automatic test_drop();
        bit ok, got, isd, bad;
        logic [15:0] dat;
        int at;
        exp_t e;
        req4(1'b1, 1'b0, 16'h0002, 16'h0000, ok);
        @(negedge clk);
        bus4.i_req  = 1'b1;
        bus4.i_addr = 16'h0010;
        #1;
        checks++;
        if (bus4.i_ready !== 1'b0) begin
            failures++;
            $display("FAIL drop_ready_while_busy: i_ready=%b required 0", bus4.i_ready);
        end
        @(negedge clk);
        bus4.i_req = 1'b0;
        collect4(12, got, isd, dat, at);
        pop4(e);
        checks++;
        if (!got || isd !== e.is_d || dat !== e.data || at != e.due) begin
            failures++;
            $display("FAIL drop_d_resp: got valid=%0b d=%0b data=%h cyc=%0d, required d=%0b data=%h cyc=%0d",
                     got, isd, dat, at, e.is_d, e.data, e.due);
        end
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (bus4.i_valid !== 1'b0 || bus4.d_valid !== 1'b0 || bus4.busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL drop_no_txn: activity seen=%b required 0", bad);
        end
    endtask

    task automatic test_reset_abort();
        bit ok, got, isd, bad;
        logic [15:0] dat;
        int at;
        exp_t e;
        req4(1'b1, 1'b1, 16'h0030, 16'h0BAD, ok);
        collect4(12, got, isd, dat, at);
        pop4(e);
        checks++;
        if (!got || isd !== e.is_d || dat !== e.data || at != e.due) begin
            failures++;
            $display("FAIL preload_0bad: got valid=%0b d=%0b data=%h cyc=%0d, required d=%0b data=%h cyc=%0d",
                     got, isd, dat, at, e.is_d, e.data, e.due);
        end
        @(negedge clk);
        bus4.d_req   = 1'b1;
        bus4.d_wr    = 1'b1;
        bus4.d_addr  = 16'h0030;
        bus4.d_wdata = 16'h5555;
        #1;
        checks++;
        if (bus4.d_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_accept: d_ready=%b required 1", bus4.d_ready);
        end
        @(negedge clk);
        bus4.d_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus4.i_valid, bus4.d_valid, bus4.busy, bus4.i_data, bus4.d_rdata} !== 35'd0) begin
            failures++;
            $display("FAIL abort_reset_outputs: outputs=%h required 0", {bus4.i_valid, bus4.d_valid,
                     bus4.busy, bus4.i_data, bus4.d_rdata});
        end
        @(negedge clk);
        rst = 1'b0;
        last_d4 = 16'h0000;
        last_i4 = 16'h0000;
        last_d1 = 16'h0000;
        bad = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            #1;
            if (bus4.d_valid !== 1'b0 || bus4.i_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL abort_no_valid: pulse seen=%b required 0", bad);
        end
        req4(1'b1, 1'b0, 16'h0030, 16'h0000, ok);
        collect4(12, got, isd, dat, at);
        pop4(e);
        checks++;
        if (!got || isd !== e.is_d || dat !== e.data || at != e.due) begin
            failures++;
            $display("FAIL abort_old_data: got valid=%0b d=%0b data=%h cyc=%0d, required d=%0b data=%h cyc=%0d",
                     got, isd, dat, at, e.is_d, e.data, e.due);
        end
    endtask

    task automatic test_latency1();
        logic [15:0] addrs [8] = '{16'h0100, 16'h0103, 16'h0104, 16'h0106,
                                   16'h0107, 16'h0101, 16'h0102, 16'h0105};
        logic [15:0] wd    [8] = '{16'hA001, 16'hB002, 16'hC003, 16'hD004,
                                   16'h0000, 16'h0000, 16'h0000, 16'h0000};
        exp_t e;
        for (int s = 0; s <= 9; s++) begin
            @(negedge clk);
            if (s < 8) begin
                bus1.d_req   = 1'b1;
                bus1.d_wr    = (s < 4);
                bus1.d_addr  = addrs[s];
                bus1.d_wdata = wd[s];
            end else begin
                bus1.d_req = 1'b0;
            end
            #1;
            checks++;
            if (bus1.busy !== (s >= 1 && s <= 8)) begin
                failures++;
                $display("FAIL lat1_busy s%0d: busy=%b required %b", s, bus1.busy, (s >= 1 && s <= 8));
            end
            checks++;
            if (bus1.d_valid !== (s >= 1 && s <= 8) || bus1.i_valid !== 1'b0) begin
                failures++;
                $display("FAIL lat1_valid s%0d: d_valid=%b i_valid=%b required %b/0",
                         s, bus1.d_valid, bus1.i_valid, (s >= 1 && s <= 8));
            end
            if (bus1.d_valid === 1'b1) begin
                pop1(e);
                checks++;
                if (bus1.d_rdata !== e.data || cyc != e.due) begin
                    failures++;
                    $display("FAIL lat1_data s%0d: d_rdata=%h cyc=%0d required %h cyc=%0d",
                             s, bus1.d_rdata, cyc, e.data, e.due);
                end
            end
            if (s < 8) begin
                checks++;
                if (bus1.d_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL lat1_ready s%0d: d_ready=%b required 1", s, bus1.d_ready);
                end else begin
                    push1(s < 4, addrs[s], wd[s]);
                end
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus4.i_req   = 1'b0;
        bus4.i_addr  = 16'h0000;
        bus4.d_req   = 1'b0;
        bus4.d_wr    = 1'b0;
        bus4.d_addr  = 16'h0000;
        bus4.d_wdata = 16'h0000;
        bus1.i_req   = 1'b0;
        bus1.i_addr  = 16'h0000;
        bus1.d_req   = 1'b0;
        bus1.d_wr    = 1'b0;
        bus1.d_addr  = 16'h0000;
        bus1.d_wdata = 16'h0000;

        test_reset();
        test_single_read();
        test_arbitration();
        test_write_read();
        test_drop();
        test_reset_abort();
        test_latency1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
